// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU/branch opcodes, M-extension
// funct3 codes and the multiply/divide sequencer state.
package exe_pkg;

  // Sixteen 4-bit codes carry twelve ALU operations and six branch compares.
  // BLT and BLTU reuse the SLT/SLTU codes: the compare is identical, and the
  // instruction is treated as a branch when it does not write a register
  // (branches never set rd_wen).
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,   // also BLT when rd_wen = 0
    ALU_SLTU  = 4'd9,   // also BLTU when rd_wen = 0
    ALU_JALR  = 4'd10,
    ALU_COPY1 = 4'd11,
    ALU_BEQ   = 4'd12,
    ALU_BNE   = 4'd13,
    ALU_BGE   = 4'd14,
    ALU_BGEU  = 4'd15
  } alu_op_e;

  // RISC-V M-extension funct3.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// clock on operand magnitudes, with signs and RISC-V corner cases applied to
// the final value. Operands and md_op are held stable by the execute stage
// for the whole operation, so only the working registers live here.
module md_unit
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            es_valid,
  input  logic            md_en,
  input  logic            ms_allowin,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;   // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;   // multiplier / dividend shifting into quotient

  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_s;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand signedness, magnitudes and divide corner-case detection
  always_comb begin
    is_div   = md_op[2];
    a_signed = (md_op == MD_MULH) || (md_op == MD_MULHSU) ||
               (md_op == MD_DIV)  || (md_op == MD_REM);
    b_signed = (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
    a_neg    = a_signed && op1[XLEN-1];
    b_neg    = b_signed && op2[XLEN-1];
    a_mag    = neg_if(op1, a_neg);
    b_mag    = neg_if(op2, b_neg);
    div_zero = (op2 == '0);
    div_ovf  = b_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  end

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
  end

  // Sequencer next state: load on start, XLEN iterations, hold until handoff
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (es_valid && md_en) begin
          state_d = MD_BUSY;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = a_mag;
        end
      end
      MD_BUSY: begin
        if (is_div) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (es_valid && ms_allowin) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  // Sequencer state and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Final result: sign correction and divide-by-zero / overflow values
  always_comb begin
    prod_s = neg2_if({hi_q, lo_q}, a_neg ^ b_neg);
    result = '0;
    case (md_op)
      MD_MUL:                       result = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = div_zero ? '1 :
                                             div_ovf  ? op1 : neg_if(lo_q, a_neg ^ b_neg);
      default:                      result = div_zero ? op1 :
                                             div_ovf  ? '0 : neg_if(hi_q, a_neg);
    endcase
  end

  assign done = (state_q == MD_DONE);

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: latches one instruction from decode, evaluates ALU ops and
// branch conditions in a single cycle, runs M-extension ops on the iterative
// md_unit, and provides the forwarding bus and fetch redirect.
module exe_stage_md
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int HAS_M  = 1,
  parameter int CTRL_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ds_to_es_valid,
  output logic              es_allowin,
  input  logic              es_flush,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  input  logic [3:0]        alu_op,
  input  logic              md_en,
  input  logic [2:0]        md_op,
  input  logic              jmp_flag,
  input  logic [XLEN-1:0]   br_target,
  input  logic [4:0]        rd,
  input  logic              rd_wen,
  input  logic [XLEN-1:0]   pc,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              ms_allowin,
  output logic              es_to_ms_valid,
  output logic [XLEN-1:0]   es_result,
  output logic [4:0]        es_rd,
  output logic              es_rd_wen,
  output logic [XLEN-1:0]   es_pc,
  output logic [CTRL_W-1:0] es_ctrl,
  output logic              jmp_valid,
  output logic [XLEN-1:0]   jmp_target,
  output logic              fwd_valid,
  output logic              fwd_busy,
  output logic [4:0]        fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  localparam int SH_W = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   pc;
    logic [3:0]        alu_op;
    logic              md_en;
    logic [2:0]        md_op;
    logic              jmp_flag;
    logic [4:0]        rd;
    logic              rd_wen;
    logic [CTRL_W-1:0] ctrl;
  } es_bus_t;

  es_bus_t         bus_q, bus_d;
  logic            es_valid_q, es_valid_d;
  logic            es_ready_go;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] alu_res, add_res, sub_res;
  logic [SH_W-1:0] shamt;
  logic            lt_s, lt_u, eq, br_taken;

  assign es_ready_go    = !bus_q.md_en || md_done;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  // Stage valid and instruction fields; flush wins over a simultaneous latch
  always_comb begin
    es_valid_d = es_valid_q;
    bus_d      = bus_q;
    if (es_allowin) es_valid_d = ds_to_es_valid;
    if (ds_to_es_valid && es_allowin && !es_flush) begin
      bus_d.op1       = op1;
      bus_d.op2       = op2;
      bus_d.br_target = br_target;
      bus_d.pc        = pc;
      bus_d.alu_op    = alu_op;
      bus_d.md_en     = md_en;
      bus_d.md_op     = md_op;
      bus_d.jmp_flag  = jmp_flag;
      bus_d.rd        = rd;
      bus_d.rd_wen    = rd_wen;
      bus_d.ctrl      = ctrl_in;
    end
    if (es_flush) es_valid_d = 1'b0;
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      bus_q      <= bus_d;
    end
  end

  // Single-cycle ALU and compare results
  always_comb begin
    shamt   = bus_q.op2[SH_W-1:0];
    add_res = bus_q.op1 + bus_q.op2;
    sub_res = bus_q.op1 - bus_q.op2;
    lt_s    = $signed(bus_q.op1) < $signed(bus_q.op2);
    lt_u    = bus_q.op1 < bus_q.op2;
    eq      = (bus_q.op1 == bus_q.op2);
    alu_res = '0;
    case (bus_q.alu_op)
      ALU_ADD:   alu_res = add_res;
      ALU_SUB:   alu_res = sub_res;
      ALU_AND:   alu_res = bus_q.op1 & bus_q.op2;
      ALU_OR:    alu_res = bus_q.op1 | bus_q.op2;
      ALU_XOR:   alu_res = bus_q.op1 ^ bus_q.op2;
      ALU_SLL:   alu_res = bus_q.op1 << shamt;
      ALU_SRL:   alu_res = bus_q.op1 >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(bus_q.op1) >>> shamt);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_JALR:  alu_res = {add_res[XLEN-1:1], 1'b0};
      ALU_COPY1: alu_res = bus_q.op1;
      ALU_BEQ:   alu_res = {{(XLEN-1){1'b0}}, eq};
      ALU_BNE:   alu_res = {{(XLEN-1){1'b0}}, !eq};
      ALU_BGE:   alu_res = {{(XLEN-1){1'b0}}, !lt_s};
      ALU_BGEU:  alu_res = {{(XLEN-1){1'b0}}, !lt_u};
      default:   alu_res = '0;
    endcase
  end

  // Branch condition; SLT/SLTU codes act as BLT/BLTU when no register is written
  always_comb begin
    br_taken = 1'b0;
    case (bus_q.alu_op)
      ALU_BEQ:  br_taken = eq;
      ALU_BNE:  br_taken = !eq;
      ALU_BGE:  br_taken = !lt_s;
      ALU_BGEU: br_taken = !lt_u;
      ALU_SLT:  br_taken = !bus_q.rd_wen && lt_s;
      ALU_SLTU: br_taken = !bus_q.rd_wen && lt_u;
      default:  br_taken = 1'b0;
    endcase
  end

  generate
    if (HAS_M != 0) begin : g_md
      md_unit #(
        .XLEN(XLEN)
      ) u_md (
        .clk       (clk),
        .rst       (rst),
        .flush     (es_flush),
        .es_valid  (es_valid_q),
        .md_en     (bus_q.md_en),
        .ms_allowin(ms_allowin),
        .md_op     (bus_q.md_op),
        .op1       (bus_q.op1),
        .op2       (bus_q.op2),
        .done      (md_done),
        .result    (md_result)
      );
    end else begin : g_no_md
      assign md_done   = 1'b1;
      assign md_result = '0;
    end
  endgenerate

  assign es_result  = bus_q.md_en ? md_result : alu_res;
  assign es_rd      = bus_q.rd;
  assign es_rd_wen  = bus_q.rd_wen;
  assign es_pc      = bus_q.pc;
  assign es_ctrl    = bus_q.ctrl;

  assign jmp_valid  = es_valid_q && (bus_q.jmp_flag || br_taken);
  assign jmp_target = (bus_q.alu_op == ALU_JALR) ? alu_res : bus_q.br_target;

  assign fwd_valid  = es_valid_q && bus_q.rd_wen;
  assign fwd_busy   = es_valid_q && !es_ready_go;
  assign fwd_rd     = bus_q.rd;
  assign fwd_data   = es_result;

endmodule

// File: tb/tb_exe_stage_md.sv
// Scoreboard bench for exe_stage_md: the driver pushes the hand-computed
// result of every instruction that must reach the memory stage; a monitor
// pops and compares on each handoff (es_to_ms_valid && ms_allowin).
module tb_exe_stage_md;
  import exe_pkg::*;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic              ds_to_es_valid;
  logic              es_allowin;
  logic              es_flush;
  logic [XLEN-1:0]   op1, op2;
  logic [3:0]        alu_op;
  logic              md_en;
  logic [2:0]        md_op;
  logic              jmp_flag;
  logic [XLEN-1:0]   br_target;
  logic [4:0]        rd;
  logic              rd_wen;
  logic [XLEN-1:0]   pc;
  logic [CTRL_W-1:0] ctrl_in;
  logic              ms_allowin;
  logic              es_to_ms_valid;
  logic [XLEN-1:0]   es_result;
  logic [4:0]        es_rd;
  logic              es_rd_wen;
  logic [XLEN-1:0]   es_pc;
  logic [CTRL_W-1:0] es_ctrl;
  logic              jmp_valid;
  logic [XLEN-1:0]   jmp_target;
  logic              fwd_valid;
  logic              fwd_busy;
  logic [4:0]        fwd_rd;
  logic [XLEN-1:0]   fwd_data;

  always #5 clk = ~clk;

  exe_stage_md #(.XLEN(XLEN), .HAS_M(1), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .es_flush(es_flush), .op1(op1), .op2(op2), .alu_op(alu_op), .md_en(md_en),
    .md_op(md_op), .jmp_flag(jmp_flag), .br_target(br_target), .rd(rd),
    .rd_wen(rd_wen), .pc(pc), .ctrl_in(ctrl_in), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_rd(es_rd),
    .es_rd_wen(es_rd_wen), .es_pc(es_pc), .es_ctrl(es_ctrl), .jmp_valid(jmp_valid),
    .jmp_target(jmp_target), .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [XLEN-1:0]   res;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Driver acts 1 ns after the falling edge; the monitor samples at 2 ns.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present one instruction, hold it until accepted, return one cycle after the latching edge.
  task automatic issue(input logic [3:0] aop, input logic m, input logic [2:0] mop,
                       input logic [31:0] a, input logic [31:0] b, input logic jf,
                       input logic [31:0] bt, input logic [4:0] r, input logic w,
                       input logic [31:0] p, input logic [31:0] exp_res, input bit expect_out);
    int   n;
    exp_t e;
    step();
    alu_op = aop; md_en = m; md_op = mop; op1 = a; op2 = b; jmp_flag = jf;
    br_target = bt; rd = r; rd_wen = w; pc = p; ctrl_in = {16'hA5A5, p};
    ds_to_es_valid = 1'b1;
    n = 0;
    while (!es_allowin && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: es_allowin stayed 0 for %0d cycles, expected 1", n);
    end
    if (expect_out) begin
      e.res = exp_res; e.pc = p; e.rd = r; e.ctrl = {16'hA5A5, p};
      exp_q.push_back(e);
    end
    step();
    ds_to_es_valid = 1'b0;
  endtask

  // Cycles from one cycle after latch until es_to_ms_valid; also whether fwd_busy held meanwhile.
  task automatic wait_out(output int k, output bit busy_ok);
    k = 0;
    busy_ok = 1'b1;
    while (!es_to_ms_valid && k < 200) begin
      if (!fwd_busy) busy_ok = 1'b0;
      step();
      k++;
    end
  endtask

  task automatic md_test(input string name, input logic [2:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic [31:0] p);
    int k;
    bit bz;
    issue(ALU_ADD, 1'b1, mop, a, b, 1'b0, 32'h0, 5'd10, 1'b1, p, exp_res, 1'b1);
    wait_out(k, bz);
    chk({name, " latency"}, 64'(k), 64'(XLEN + 1));
    chk({name, " fwd_busy"}, 64'(bz), 64'd1);
  endtask

  task automatic alu_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic [31:0] p);
    issue(op, 1'b0, 3'd0, a, b, 1'b0, 32'h0, 5'd7, 1'b1, p, exp_res, 1'b1);
    chk({name, " one_cycle"}, 64'(es_to_ms_valid), 64'd1);
    chk({name, " jmp_valid"}, 64'(jmp_valid), 64'd0);
  endtask

  task automatic br_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic jf, input logic [31:0] bt,
                        input logic exp_jmp, input logic [31:0] exp_tgt,
                        input logic [31:0] exp_res, input logic [31:0] p);
    issue(op, 1'b0, 3'd0, a, b, jf, bt, 5'd0, 1'b0, p, exp_res, 1'b1);
    chk({name, " jmp_valid"}, 64'(jmp_valid), 64'(exp_jmp));
    chk({name, " jmp_target"}, 64'(jmp_target), 64'(exp_tgt));
    chk({name, " fwd_valid"}, 64'(fwd_valid), 64'd0);
  endtask

  // Monitor: every handoff must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && es_to_ms_valid && ms_allowin) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handoff: result 0x%0h pc 0x%0h, no transfer expected",
                   es_result, es_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb result", 64'(es_result), 64'(e.res));
          chk("sb rd_pc", {27'd0, es_rd, es_pc}, {27'd0, e.rd, e.pc});
          chk("sb ctrl", 64'(es_ctrl), 64'(e.ctrl));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit bz;
    rst = 1'b1; ds_to_es_valid = 1'b0; es_flush = 1'b0; ms_allowin = 1'b1;
    op1 = '0; op2 = '0; alu_op = '0; md_en = 1'b0; md_op = '0; jmp_flag = 1'b0;
    br_target = '0; rd = '0; rd_wen = 1'b0; pc = '0; ctrl_in = '0;
    repeat (3) step();

    chk("rst es_allowin", 64'(es_allowin), 64'd1);
    chk("rst es_to_ms_valid", 64'(es_to_ms_valid), 64'd0);
    chk("rst jmp_valid", 64'(jmp_valid), 64'd0);
    chk("rst fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst fwd_busy", 64'(fwd_busy), 64'd0);
    chk("rst es_result", 64'(es_result), 64'd0);
    chk("rst es_pc", 64'(es_pc), 64'd0);
    rst = 1'b0;

    // MUL 7 x -3 with forwarding bus checks while busy
    issue(ALU_ADD, 1'b1, MD_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'h0, 5'd3, 1'b1,
          32'h1000, 32'hFFFF_FFEB, 1'b1);
    chk("mul fwd_valid", 64'(fwd_valid), 64'd1);
    chk("mul fwd_rd", 64'(fwd_rd), 64'd3);
    chk("mul allowin_busy", 64'(es_allowin), 64'd0);
    wait_out(k, bz);
    chk("mul latency", 64'(k), 64'd33);
    chk("mul fwd_busy", 64'(bz), 64'd1);
    chk("mul fwd_data", 64'(fwd_data), 64'hFFFF_FFEB);

    md_test("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1004);
    md_test("mulh", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1008);
    md_test("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h100C);
    md_test("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1010);
    md_test("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1014);
    md_test("divu_zero", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'h1018);
    md_test("remu_zero", MD_REMU, 32'd100, 32'd0, 32'd100, 32'h101C);
    md_test("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'h1020);
    md_test("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'h1024);

    alu_chk("add", ALU_ADD, 32'd2, 32'd3, 32'd5, 32'h2000);
    alu_chk("sub", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h2004);
    alu_chk("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h2008);
    alu_chk("or", ALU_OR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'h200C);
    alu_chk("xor", ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'h2010);
    alu_chk("sll", ALU_SLL, 32'd1, 32'h21, 32'd2, 32'h2014);
    alu_chk("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'h2018);
    alu_chk("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'h201C);
    alu_chk("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h2020);
    alu_chk("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h2024);
    alu_chk("copy1", ALU_COPY1, 32'h1234_ABCD, 32'd5, 32'h1234_ABCD, 32'h2028);

    br_chk("bne", ALU_BNE, 32'd1, 32'd2, 1'b0, 32'h100, 1'b1, 32'h100, 32'd1, 32'h3000);
    br_chk("beq", ALU_BEQ, 32'd1, 32'd2, 1'b0, 32'h104, 1'b0, 32'h104, 32'd0, 32'h3004);
    br_chk("blt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h200, 1'b1, 32'h200, 32'd1, 32'h3008);
    br_chk("bgeu", ALU_BGEU, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h208, 1'b0, 32'h208, 32'd0, 32'h300C);
    br_chk("bge", ALU_BGE, 32'd5, 32'hFFFF_FFFF, 1'b0, 32'h300, 1'b1, 32'h300, 32'd1, 32'h3010);
    br_chk("jalr", ALU_JALR, 32'h203, 32'd0, 1'b1, 32'h999, 1'b1, 32'h202, 32'h202, 32'h3014);

    // Flush at BUSY cycle 10: nothing delivered, then single-cycle ADD, then full-latency MUL
    issue(ALU_ADD, 1'b1, MD_DIV, 32'd1000, 32'd7, 1'b0, 32'h0, 5'd4, 1'b1, 32'h4000, 32'h0, 1'b0);
    repeat (10) step();
    es_flush = 1'b1;
    step();
    es_flush = 1'b0;
    chk("flush es_allowin", 64'(es_allowin), 64'd1);
    chk("flush fwd_busy", 64'(fwd_busy), 64'd0);
    chk("flush es_to_ms_valid", 64'(es_to_ms_valid), 64'd0);
    alu_chk("post_flush_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 32'h4004);
    md_test("post_flush_mul", MD_MUL, 32'd9, 32'd11, 32'd99, 32'h4008);

    // Backpressure in DONE for 5 cycles, then exactly one handoff
    issue(ALU_ADD, 1'b1, MD_MUL, 32'd6, 32'd7, 1'b0, 32'h0, 5'd5, 1'b1, 32'h5000, 32'd42, 1'b1);
    ms_allowin = 1'b0;
    wait_out(k, bz);
    chk("bp latency", 64'(k), 64'd33);
    for (int i = 0; i < 5; i++) begin
      chk("bp result_held", 64'(es_result), 64'd42);
      chk("bp es_allowin", 64'(es_allowin), 64'd0);
      chk("bp valid_held", 64'(es_to_ms_valid), 64'd1);
      step();
    end
    ms_allowin = 1'b1;
    step();
    chk("bp single_handoff", 64'(es_to_ms_valid), 64'd0);
    chk("bp allowin_after", 64'(es_allowin), 64'd1);
    md_test("post_bp_mulhu", MD_MULHU, 32'h8000_0000, 32'd4, 32'd2, 32'h5004);

    // Reset while BUSY abandons the operation
    issue(ALU_ADD, 1'b1, MD_MUL, 32'd3, 32'd3, 1'b0, 32'h0, 5'd6, 1'b1, 32'h6000, 32'd9, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy es_to_ms_valid", 64'(es_to_ms_valid), 64'd0);
    chk("rst_busy fwd_busy", 64'(fwd_busy), 64'd0);
    chk("rst_busy fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_busy es_allowin", 64'(es_allowin), 64'd1);
    repeat (40) step();
    md_test("post_rst_divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 32'h6004);

    repeat (3) step();
    chk("sb drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
